// File: rtl/mult4_pkg.sv
// Shared state encoding and Shift-block codes for the sequential 4x4 multiplier.
package mult4_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PP0,
      PP1,
      PP2,
      PP3,
      FIN
   } mult4_state_t;

   localparam logic [1:0] SH_X1  = 2'b00;
   localparam logic [1:0] SH_X4  = 2'b01;
   localparam logic [1:0] SH_X16 = 2'b10;

endpackage

// File: rtl/Shift.sv
// Shared 4-to-8 alignment block: code 00 = x1, 01 = x4, 10 = x16.
module Shift (
   input  logic [3:0] din,
   input  logic [1:0] sh,
   output logic [7:0] dout
);

   always_comb begin
      dout = 8'h00;
      case (sh)
         2'b00:   dout = {4'b0000, din};
         2'b01:   dout = {2'b00, din, 2'b00};
         2'b10:   dout = {din, 4'b0000};
         default: dout = 8'h00;
      endcase
   end

endmodule

// File: rtl/mult2x2.sv
// Combinational 2x2 unsigned multiply producing a 4-bit partial product.
module mult2x2 (
   input  logic [1:0] a,
   input  logic [1:0] b,
   output logic [3:0] p
);

   assign p = {2'b00, a} * {2'b00, b};

endmodule

// File: rtl/mult4_seq_ctrl.sv
// Four-cycle 4x4 multiplier: one 2x2 multiplier plus Shift, accumulated into product.
// Optional MULT4_ZERO_SKIP_EN finishes zero-operand multiplies in a single cycle.
module mult4_seq_ctrl
   import mult4_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic       ready,
   output logic       busy,
   output logic       done,
   output logic [7:0] product
);

   mult4_state_t state;
   logic [3:0]   a_r;
   logic [3:0]   b_r;
   logic [1:0]   a_sel;
   logic [1:0]   b_sel;
   logic [1:0]   sh_code;
   logic [3:0]   pp;
   logic [7:0]   pp_aligned;
   logic         skip;

`ifdef MULT4_ZERO_SKIP_EN
   assign skip = (a == 4'h0) || (b == 4'h0);
`else
   assign skip = 1'b0;
`endif

   // Operand halves and alignment depend only on registered state.
   always_comb begin
      a_sel   = a_r[1:0];
      b_sel   = b_r[1:0];
      sh_code = SH_X1;
      case (state)
         PP1: begin
            a_sel   = a_r[3:2];
            sh_code = SH_X4;
         end
         PP2: begin
            b_sel   = b_r[3:2];
            sh_code = SH_X4;
         end
         PP3: begin
            a_sel   = a_r[3:2];
            b_sel   = b_r[3:2];
            sh_code = SH_X16;
         end
         default: ;
      endcase
   end

   mult2x2 u_mult2x2 (
      .a (a_sel),
      .b (b_sel),
      .p (pp)
   );

   Shift u_shift (
      .din  (pp),
      .sh   (sh_code),
      .dout (pp_aligned)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         a_r     <= 4'h0;
         b_r     <= 4'h0;
         product <= 8'h00;
         ready   <= 1'b1;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         case (state)
            IDLE, FIN: begin
               if (start) begin
                  a_r     <= a;
                  b_r     <= b;
                  product <= 8'h00;
                  if (skip) begin
                     state <= FIN;
                     ready <= 1'b1;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     state <= PP0;
                     ready <= 1'b0;
                     busy  <= 1'b1;
                     done  <= 1'b0;
                  end
               end else begin
                  state <= IDLE;
                  ready <= 1'b1;
                  busy  <= 1'b0;
                  done  <= 1'b0;
               end
            end
            PP0, PP1, PP2: begin
               product <= product + pp_aligned;
               state   <= (state == PP0) ? PP1 : (state == PP1) ? PP2 : PP3;
               ready   <= 1'b0;
               busy    <= 1'b1;
               done    <= 1'b0;
            end
            PP3: begin
               product <= product + pp_aligned;
               state   <= FIN;
               ready   <= 1'b1;
               busy    <= 1'b0;
               done    <= 1'b1;
            end
            default: begin
               state <= IDLE;
               ready <= 1'b1;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/mult4_seq_ctrl.md
# mult4_seq_ctrl

Sequential controller for a 4x4 unsigned multiplier. It reuses one 2x2 partial-product multiplier and the team's 4-to-8 `Shift` block over four cycles, accumulating the aligned partial products into an 8-bit register. It sits between the FPGA top-level operand registers and the result bus, and it owns all shift-control sequencing for the `Shift` block.

## Interface
- No parameters; widths are fixed at 4-bit operands and an 8-bit product.
- `clk`  in  1  single system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a multiply. Sampled only while `ready`=1.
- `a`  in  4  multiplicand. Captured on the accepted `start`.
- `b`  in  4  multiplier. Captured on the accepted `start`.
- `ready`  out  1  the block can accept `start`. Reset value 1.
- `busy`  out  1  a multiply is in progress. Reset value 0.
- `done`  out  1  one-cycle pulse; `product` is valid. Reset value 0.
- `product`  out  8  accumulator/result. Holds its value until the next accepted `start`. Reset value 8'h00.

## Operation
- States: IDLE, PP0, PP1, PP2, PP3, FIN.
- IDLE
  - `ready`=1.
  - If `start`: capture `a`/`b` into `a_r`/`b_r`, clear the accumulator, go to PP0.
- Partial products are formed as the 2x2 product of the selected halves, then shifted by `Shift`, then added to the accumulator:
  - PP0: `a_r[1:0]`*`b_r[1:0]`, shift code 00 (x1), go to PP1.
  - PP1: `a_r[3:2]`*`b_r[1:0]`, shift code 01 (x4), go to PP2.
  - PP2: `a_r[1:0]`*`b_r[3:2]`, shift code 01 (x4), go to PP3.
  - PP3: `a_r[3:2]`*`b_r[3:2]`, shift code 10 (x16), go to FIN.
- FIN
  - `done`=1 and `ready`=1.
  - If `start`: capture new operands, clear the accumulator, go to PP0 (back-to-back operation).
  - Otherwise go to IDLE.
- Shift code 11 is never driven.
- Arithmetic: the accumulator is 8-bit unsigned with no carry-out. The maximum result is 15*15=225, so overflow cannot occur and every intermediate sum is at most the final result.
- `busy`=1 in PP0..PP3 only.
- `start` while `busy` is ignored. Changes to `a`/`b` while `busy` have no effect.
- `rst` has priority over every other input in every state:
  - Next state is IDLE, `product`=0, `done`=0.
  - An aborted operation never produces `done`.

## Timing
- `start` sampled at edge N: PP0..PP3 occupy cycles N+1..N+4, and `done`=1 during cycle N+5 with the final `product`.
- Latency is 5 cycles from the accepted `start` to `done`.
- Throughput is one result per 5 cycles when `start` is asserted in every FIN cycle.
- `product` updates on each PPx edge. It is only architecturally valid when `done`=1 and afterwards, until the next accepted `start`.
- All outputs are registered or decoded from registered state only. There is no combinational path from `start`, `a` or `b` to any output.

## Configuration
- `MULT4_ZERO_SKIP_EN` defined:
  - If the captured `a_r`==0 or `b_r`==0, IDLE/FIN go directly to FIN on the next edge with `product`=0.
  - `done` then asserts at N+1.
  - `busy` stays 0 for that operation.
- Not defined: zero operands take the full 5-cycle path like any other operands.

## Structure
- `mult4_pkg` contains:
  - the state enum `mult4_state_t` (IDLE, PP0..PP3, FIN);
  - the shift-code constants `SH_X1`=2'b00, `SH_X4`=2'b01, `SH_X16`=2'b10.
- Sub-module `mult2x2`: purely combinational 2x2 to 4-bit unsigned multiply.
- The existing `Shift` block is instantiated unchanged.
- The FSM, operand registers and accumulator live in `mult4_seq_ctrl`.

## Test plan
- Reset: `rst`=1 for 2 cycles -> `ready`=1, `busy`=0, `done`=0, `product`=8'h00.
- `a`=4'hF, `b`=4'hF, one-cycle `start` -> `busy`=1 for cycles N+1..N+4, `done` pulse at N+5, `product`=8'hE1.
- `a`=4'h6, `b`=4'h9 -> `product`=8'h36 at `done`. Hold `start`=1 and switch `a`/`b` to 3/3 during `busy` -> still 8'h36, with no extra `done` until FIN.
- Back-to-back: assert `start` in the FIN cycle with `a`=2, `b`=7 -> second `done` 5 cycles later, `product`=8'h0E.
- Assert `rst` during PP2 of `a`=4'hA, `b`=4'h5 -> next cycle IDLE, `product`=8'h00, no `done` pulse. A following `start` with 4'h3*4'h4 -> 8'h0C.
- Zero operands, `a`=0, `b`=4'h9:
  - with `MULT4_ZERO_SKIP_EN` -> `done` at N+1, `product`=0;
  - without it -> `done` at N+5, `product`=0.
